// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: receives a byte stream (2-byte word count, then big-endian words),
// writes each word to consecutive instruction memory addresses and releases the CPU reset when done.
module instr_mem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    output logic             rx_ready_o,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_data_o,
    output logic             cpu_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_loaded_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0]      DEPTH_W = DEPTH;
    localparam logic [CNT_W-1:0] ONE     = 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [7:0]         hdr_hi_q, hdr_hi_d;
    logic [31:0]        word_q, word_d;
    logic [CNT_W-1:0]   words_d;
    logic [CNT_W-1:0]   words_inc;
    logic [31:0]        addr_d, data_d;
    logic [15:0]        hdr_count;
    logic               accept;

    assign accept    = rx_valid_i & rx_ready_o;
    assign hdr_count = {hdr_hi_q, rx_data_i};
    assign words_inc = words_loaded_o + ONE;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        hdr_hi_d   = hdr_hi_q;
        word_d     = word_q;
        words_d    = words_loaded_o;
        addr_d     = imem_addr_o;
        data_d     = imem_data_o;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d    = HDR;
                    count_d    = '0;
                    byte_idx_d = '0;
                    words_d    = '0;
                end
            end
            HDR: begin
                if (accept) begin
                    if (byte_idx_q == 2'd0) begin
                        hdr_hi_d   = rx_data_i;
                        byte_idx_d = 2'd1;
                    end else begin
                        byte_idx_d = 2'd0;
                        count_d    = CNT_W'(hdr_count);
                        if (hdr_count == 16'd0) begin
                            state_d = DONE;
                        end else if ({16'd0, hdr_count} > DEPTH_W) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d     = {word_q[23:0], rx_data_i};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                words_d    = words_inc;
                byte_idx_d = '0;
                state_d    = (words_inc == count_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase

        // The write strobe, address and data are registered, so they are prepared on the edge entering WRITE.
        if (state_d == WRITE) begin
            addr_d = 32'({words_loaded_o, 2'b00});
            data_d = word_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            byte_idx_q     <= '0;
            hdr_hi_q       <= '0;
            word_q         <= '0;
            words_loaded_o <= '0;
            imem_addr_o    <= '0;
            imem_data_o    <= '0;
            imem_we_o      <= 1'b0;
            rx_ready_o     <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            cpu_rst_n_o    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_idx_q     <= byte_idx_d;
            hdr_hi_q       <= hdr_hi_d;
            word_q         <= word_d;
            words_loaded_o <= words_d;
            imem_addr_o    <= addr_d;
            imem_data_o    <= data_d;
            imem_we_o      <= (state_d == WRITE);
            rx_ready_o     <= (state_d == HDR) || (state_d == DATA);
            busy_o         <= (state_d == HDR) || (state_d == DATA) || (state_d == WRITE);
            done_o         <= (state_d == DONE);
            err_o          <= (state_d == ERR);
            cpu_rst_n_o    <= (state_d == DONE);
        end
    end

endmodule
